// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit encoding, head-flit field layout and NI transmitter states.
// Imported by the network-interface transmitter and by the router-side receive logic.
package noc_pkg;

  localparam int NOC_DATA_W  = 32;
  localparam int NOC_COORD_W = 4;
  localparam int NOC_LEN_W   = 4;

  typedef enum logic [1:0] {
    FLIT_BODY     = 2'b00,
    FLIT_HEAD     = 2'b01,
    FLIT_TAIL     = 2'b10,
    FLIT_HEADTAIL = 2'b11
  } flit_type_e;

  typedef struct packed {
    flit_type_e              ftype;
    logic [NOC_DATA_W-1:0]   payload;
  } flit_t;

  // Head-flit fields in LSB-first order; the length field sits at bit 0.
  localparam int HF_LEN   = 0;
  localparam int HF_DST_X = 1;
  localparam int HF_DST_Y = 2;
  localparam int HF_SRC_X = 3;
  localparam int HF_SRC_Y = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HEAD = 2'b01,
    ST_BODY = 2'b10
  } ni_tx_state_e;

  // Bit offset of a head field for a given length/coordinate width.
  function automatic int head_lsb(input int field, input int len_w, input int coord_w);
    int lsb;
    if (field == HF_LEN) begin
      lsb = 32'sd0;
    end else begin
      lsb = len_w + (field - 32'sd1) * coord_w;
    end
    return lsb;
  endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// Credit counter for credit-based flow control; starts full and tracks free downstream slots.
// A return while already full is ignored and latches a sticky error.
module noc_credit_counter #(
  parameter int CREDIT_N = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             inc,
  input  logic                             dec,
  output logic [$clog2(CREDIT_N+1)-1:0]    cnt,
  output logic                             avail,
  output logic                             err
);

  localparam int CNT_W = $clog2(CREDIT_N + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CREDIT_N);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  assign avail = (cnt != {CNT_W{1'b0}});

  // Count update: a simultaneous return and consume cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= FULL;
      err <= 1'b0;
    end else begin
      case ({inc, dec})
        2'b10: begin
          if (cnt == FULL) begin
            err <= 1'b1;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        2'b01: begin
          if (cnt != {CNT_W{1'b0}}) begin
            cnt <= cnt - ONE;
          end else begin
            cnt <= cnt;
          end
        end
        default: begin
          cnt <= cnt;
        end
      endcase
    end
  end

endmodule

// File: rtl/noc_ni_tx.sv
// NoC network-interface transmitter: packetises a request plus payload words into
// HEAD/BODY/TAIL flits for the router local port under credit-based flow control.
module noc_ni_tx
  import noc_pkg::*;
#(
  parameter int DATA_W   = NOC_DATA_W,
  parameter int COORD_W  = NOC_COORD_W,
  parameter int LEN_W    = NOC_LEN_W,
  parameter int CREDIT_N = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [COORD_W-1:0]               my_xpos,
  input  logic [COORD_W-1:0]               my_ypos,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [COORD_W-1:0]               req_dst_x,
  input  logic [COORD_W-1:0]               req_dst_y,
  input  logic [LEN_W-1:0]                 req_len,
  input  logic                             data_valid,
  output logic                             data_ready,
  input  logic [DATA_W-1:0]                data_i,
  output logic                             flit_valid_o,
  output logic [DATA_W+1:0]                flit_o,
  input  logic                             credit_i,
  output logic [$clog2(CREDIT_N+1)-1:0]    credit_cnt_o,
  output logic                             err_o
);

  localparam int LEN_LSB   = head_lsb(HF_LEN,   LEN_W, COORD_W);
  localparam int DST_X_LSB = head_lsb(HF_DST_X, LEN_W, COORD_W);
  localparam int DST_Y_LSB = head_lsb(HF_DST_Y, LEN_W, COORD_W);
  localparam int SRC_X_LSB = head_lsb(HF_SRC_X, LEN_W, COORD_W);
  localparam int SRC_Y_LSB = head_lsb(HF_SRC_Y, LEN_W, COORD_W);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  ni_tx_state_e        state;
  logic [COORD_W-1:0]  dst_x;
  logic [COORD_W-1:0]  dst_y;
  logic [COORD_W-1:0]  src_x;
  logic [COORD_W-1:0]  src_y;
  logic [LEN_W-1:0]    len;
  logic [LEN_W-1:0]    remaining;

  logic                avail;
  logic                send;
  flit_type_e          send_type;
  logic [DATA_W-1:0]   send_payload;
  logic [DATA_W-1:0]   head_payload;

  noc_credit_counter #(
    .CREDIT_N (CREDIT_N)
  ) u_credit (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (credit_i),
    .dec   (send),
    .cnt   (credit_cnt_o),
    .avail (avail),
    .err   (err_o)
  );

  assign req_ready  = (state == ST_IDLE);
  assign data_ready = (state == ST_BODY) && avail;

  // Head payload assembled from the latched request; unused upper bits stay zero.
  always_comb begin
    head_payload = {DATA_W{1'b0}};
    head_payload[LEN_LSB   +: LEN_W]   = len;
    head_payload[DST_X_LSB +: COORD_W] = dst_x;
    head_payload[DST_Y_LSB +: COORD_W] = dst_y;
    head_payload[SRC_X_LSB +: COORD_W] = src_x;
    head_payload[SRC_Y_LSB +: COORD_W] = src_y;
  end

  // Send decision for this cycle: a flit leaves only while a credit is available.
  always_comb begin
    send         = 1'b0;
    send_type    = FLIT_BODY;
    send_payload = {DATA_W{1'b0}};
    case (state)
      ST_HEAD: begin
        if (avail) begin
          send         = 1'b1;
          send_type    = (len == {LEN_W{1'b0}}) ? FLIT_HEADTAIL : FLIT_HEAD;
          send_payload = head_payload;
        end else begin
          send         = 1'b0;
          send_type    = FLIT_BODY;
          send_payload = {DATA_W{1'b0}};
        end
      end
      ST_BODY: begin
        if (avail && data_valid) begin
          send         = 1'b1;
          send_type    = (remaining == LEN_ONE) ? FLIT_TAIL : FLIT_BODY;
          send_payload = data_i;
        end else begin
          send         = 1'b0;
          send_type    = FLIT_BODY;
          send_payload = {DATA_W{1'b0}};
        end
      end
      default: begin
        send         = 1'b0;
        send_type    = FLIT_BODY;
        send_payload = {DATA_W{1'b0}};
      end
    endcase
  end

  // Packet FSM with registered flit outputs; a flit decided at an edge is visible for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      dst_x        <= {COORD_W{1'b0}};
      dst_y        <= {COORD_W{1'b0}};
      src_x        <= {COORD_W{1'b0}};
      src_y        <= {COORD_W{1'b0}};
      len          <= {LEN_W{1'b0}};
      remaining    <= {LEN_W{1'b0}};
      flit_valid_o <= 1'b0;
      flit_o       <= {(DATA_W+2){1'b0}};
    end else begin
      flit_valid_o <= send;
      if (send) begin
        flit_o <= {send_type, send_payload};
      end
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            dst_x <= req_dst_x;
            dst_y <= req_dst_y;
            src_x <= my_xpos;
            src_y <= my_ypos;
            len   <= req_len;
            state <= ST_HEAD;
          end
        end
        ST_HEAD: begin
          if (avail) begin
            if (len == {LEN_W{1'b0}}) begin
              state <= ST_IDLE;
            end else begin
              remaining <= len;
              state     <= ST_BODY;
            end
          end
        end
        ST_BODY: begin
          if (send) begin
            remaining <= remaining - LEN_ONE;
            if (remaining == LEN_ONE) begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_noc_ni_tx.sv
// Self-checking bench for noc_ni_tx: flit scoreboard, table-driven packets and
// hand-written sequences for credit, backpressure and reset corner cases.
module tb_noc_ni_tx;
  import noc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  my_xpos, my_ypos;

  logic        req_valid, req_ready, data_valid, data_ready;
  logic [3:0]  req_dst_x, req_dst_y, req_len;
  logic [31:0] data_i;
  logic        flit_valid_o, credit_i, err_o;
  logic [33:0] flit_o;
  logic [2:0]  credit_cnt_o;

  logic        req_valid2, req_ready2, data_valid2, data_ready2;
  logic [3:0]  req_len2;
  logic [31:0] data_i2;
  logic        flit_valid_o2, credit_i2, err_o2;
  logic [33:0] flit_o2;
  logic [1:0]  credit_cnt_o2;

  noc_ni_tx #(.DATA_W(32), .COORD_W(4), .LEN_W(4), .CREDIT_N(4)) dut (
    .clk(clk), .rst_n(rst_n), .my_xpos(my_xpos), .my_ypos(my_ypos),
    .req_valid(req_valid), .req_ready(req_ready), .req_dst_x(req_dst_x),
    .req_dst_y(req_dst_y), .req_len(req_len), .data_valid(data_valid),
    .data_ready(data_ready), .data_i(data_i), .flit_valid_o(flit_valid_o),
    .flit_o(flit_o), .credit_i(credit_i), .credit_cnt_o(credit_cnt_o), .err_o(err_o)
  );

  noc_ni_tx #(.DATA_W(32), .COORD_W(4), .LEN_W(4), .CREDIT_N(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .my_xpos(my_xpos), .my_ypos(my_ypos),
    .req_valid(req_valid2), .req_ready(req_ready2), .req_dst_x(4'd2),
    .req_dst_y(4'd3), .req_len(req_len2), .data_valid(data_valid2),
    .data_ready(data_ready2), .data_i(data_i2), .flit_valid_o(flit_valid_o2),
    .flit_o(flit_o2), .credit_i(credit_i2), .credit_cnt_o(credit_cnt_o2), .err_o(err_o2)
  );

  int n_checks = 0;
  int n_fail   = 0;
  flit_t exp_q[$];

  typedef struct {
    logic [3:0]  mx, my, dx, dy, len;
    logic [1:0]  etype;
    logic [31:0] epay;
    logic [2:0]  ecred;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Scoreboard: every flit on dut's port must match the oldest expected flit.
  always @(negedge clk) begin
    if (flit_valid_o) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL flit_unexpected: got 0x%0h, expected no flit", flit_o);
      end else begin
        check("flit", flit_o, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_credit(input int n);
    credit_i = 1'b1;
    repeat (n) tick();
    credit_i = 1'b0;
  endtask

  task automatic push(input logic [1:0] t, input logic [31:0] p);
    flit_t f;
    f.ftype   = flit_type_e'(t);
    f.payload = p;
    exp_q.push_back(f);
  endtask

  task automatic send_pkt(input logic [3:0] dx, input logic [3:0] dy, input logic [3:0] len,
                          input logic [31:0] base, input logic [1:0] htype, input logic [31:0] hpay);
    int budget;
    push(htype, hpay);
    req_dst_x = dx; req_dst_y = dy; req_len = len; req_valid = 1'b1;
    budget = 0;
    while (!req_ready && budget < 50) begin tick(); budget++; end
    if (!req_ready) begin
      fail_now("req_wait");
      req_valid = 1'b0;
      return;
    end
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < int'(len); i++) begin
      data_i = base + 32'(i);
      data_valid = 1'b1;
      budget = 0;
      while (!data_ready && budget < 50) begin tick(); budget++; end
      if (!data_ready) begin
        fail_now("data_wait");
        break;
      end
      push((i == int'(len) - 1) ? 2'b10 : 2'b00, base + 32'(i));
      tick();
    end
    data_valid = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    vecs[0] = '{mx:4'd1,  my:4'd1,  dx:4'd2,  dy:4'd3,  len:4'd0, etype:2'b11, epay:32'h0001_1320, ecred:3'd3};
    vecs[1] = '{mx:4'd0,  my:4'd0,  dx:4'd15, dy:4'd15, len:4'd1, etype:2'b01, epay:32'h0000_0FF1, ecred:3'd2};
    vecs[2] = '{mx:4'd15, my:4'd14, dx:4'd0,  dy:4'd7,  len:4'd2, etype:2'b01, epay:32'h000E_F702, ecred:3'd1};
    vecs[3] = '{mx:4'd5,  my:4'd10, dx:4'd3,  dy:4'd12, len:4'd3, etype:2'b01, epay:32'h000A_5C33, ecred:3'd0};

    rst_n = 1'b0; my_xpos = 4'd1; my_ypos = 4'd1;
    req_valid = 1'b0; req_dst_x = 4'd0; req_dst_y = 4'd0; req_len = 4'd0;
    data_valid = 1'b0; data_i = 32'd0; credit_i = 1'b0;
    req_valid2 = 1'b0; req_len2 = 4'd0; data_valid2 = 1'b0; data_i2 = 32'd0; credit_i2 = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_credit", credit_cnt_o, 3'd4);
    check("rst_flit_valid", flit_valid_o, 1'b0);
    check("rst_flit", flit_o, 34'd0);
    check("rst_err", err_o, 1'b0);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_data_ready", data_ready, 1'b0);
    check("rst_credit2", credit_cnt_o2, 2'd2);

    // Header-only packet
    push(2'b11, 32'h0001_1320);
    req_dst_x = 4'd2; req_dst_y = 4'd3; req_len = 4'd0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("ho_no_flit_yet", flit_valid_o, 1'b0);
    tick();
    check("ho_flit_valid", flit_valid_o, 1'b1);
    check("ho_credit", credit_cnt_o, 3'd3);
    check("ho_req_ready", req_ready, 1'b1);
    tick();
    check("ho_pulse", flit_valid_o, 1'b0);
    pulse_credit(1);
    check("ho_credit_back", credit_cnt_o, 3'd4);

    // Full packet: HEAD, BODY A, BODY B, TAIL C on consecutive cycles
    push(2'b01, 32'h0001_1323);
    push(2'b00, 32'hA); push(2'b00, 32'hB); push(2'b10, 32'hC);
    req_dst_x = 4'd2; req_dst_y = 4'd3; req_len = 4'd3; req_valid = 1'b1;
    data_valid = 1'b1; data_i = 32'hA;
    tick();
    req_valid = 1'b0;
    check("fp_req_ready_busy", req_ready, 1'b0);
    check("fp_data_ready_head", data_ready, 1'b0);
    tick();
    check("fp_head_valid", flit_valid_o, 1'b1);
    check("fp_data_ready", data_ready, 1'b1);
    tick();
    check("fp_a_valid", flit_valid_o, 1'b1);
    data_i = 32'hB;
    tick();
    check("fp_b_valid", flit_valid_o, 1'b1);
    data_i = 32'hC;
    tick();
    data_valid = 1'b0;
    check("fp_c_valid", flit_valid_o, 1'b1);
    check("fp_credit0", credit_cnt_o, 3'd0);
    check("fp_req_ready_after", req_ready, 1'b1);
    check("fp_data_ready_after", data_ready, 1'b0);
    tick();
    check("fp_drained", exp_q.size(), 0);
    pulse_credit(4);
    check("fp_credit_back", credit_cnt_o, 3'd4);

    // Table-driven packets
    for (int k = 0; k < 4; k++) begin
      my_xpos = vecs[k].mx; my_ypos = vecs[k].my;
      send_pkt(vecs[k].dx, vecs[k].dy, vecs[k].len, 32'h100 * 32'(k + 1), vecs[k].etype, vecs[k].epay);
      check("tbl_credit", credit_cnt_o, vecs[k].ecred);
      check("tbl_drained", exp_q.size(), 0);
      if (vecs[k].ecred != 3'd4) pulse_credit(4 - int'(vecs[k].ecred));
      check("tbl_credit_back", credit_cnt_o, 3'd4);
    end

    // Credit return coincident with a send at full count
    my_xpos = 4'd1; my_ypos = 4'd1;
    push(2'b01, 32'h0001_1211); push(2'b10, 32'h55);
    req_dst_x = 4'd1; req_dst_y = 4'd2; req_len = 4'd1; req_valid = 1'b1;
    data_valid = 1'b1; data_i = 32'h55;
    tick();
    req_valid = 1'b0;
    credit_i = 1'b1;
    tick();
    credit_i = 1'b0;
    check("co_credit_same", credit_cnt_o, 3'd4);
    check("co_err", err_o, 1'b0);
    tick();
    data_valid = 1'b0;
    check("co_credit_after", credit_cnt_o, 3'd3);
    pulse_credit(1);
    tick();
    check("co_drained", exp_q.size(), 0);

    // Credit overflow at full count
    check("ov_start", credit_cnt_o, 3'd4);
    pulse_credit(1);
    check("ov_credit", credit_cnt_o, 3'd4);
    check("ov_err", err_o, 1'b1);
    repeat (3) tick();
    check("ov_err_sticky", err_o, 1'b1);

    // Reset mid-packet after BODY A
    push(2'b01, 32'h0001_1323); push(2'b00, 32'hA);
    req_dst_x = 4'd2; req_dst_y = 4'd3; req_len = 4'd3; req_valid = 1'b1;
    data_valid = 1'b1; data_i = 32'hA;
    tick();
    req_valid = 1'b0;
    repeat (2) tick();
    check("mr_a_valid", flit_valid_o, 1'b1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    data_valid = 1'b0;
    #1;
    check("mr_flit_low", flit_valid_o, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("mr_drained", exp_q.size(), 0);
    check("mr_req_ready", req_ready, 1'b1);
    check("mr_credit", credit_cnt_o, 3'd4);
    check("mr_err_clr", err_o, 1'b0);
    send_pkt(4'd2, 4'd3, 4'd0, 32'd0, 2'b11, 32'h0001_1320);
    check("mr_ht_credit", credit_cnt_o, 3'd3);
    check("mr_ht_drained", exp_q.size(), 0);

    // Backpressure on a 2-credit instance
    req_len2 = 4'd3; req_valid2 = 1'b1;
    data_valid2 = 1'b1; data_i2 = 32'hA;
    tick();
    req_valid2 = 1'b0;
    tick();
    check("bp_head_valid", flit_valid_o2, 1'b1);
    check("bp_head", flit_o2, {2'b01, 32'h0001_1323});
    tick();
    check("bp_a_valid", flit_valid_o2, 1'b1);
    check("bp_a", flit_o2, {2'b00, 32'hA});
    check("bp_credit0", credit_cnt_o2, 2'd0);
    data_i2 = 32'hB;
    for (int s = 0; s < 3; s++) begin
      tick();
      check("bp_stall_flit", flit_valid_o2, 1'b0);
      check("bp_stall_ready", data_ready2, 1'b0);
    end
    credit_i2 = 1'b1;
    tick();
    credit_i2 = 1'b0;
    check("bp_k_no_flit", flit_valid_o2, 1'b0);
    check("bp_k_credit", credit_cnt_o2, 2'd1);
    tick();
    check("bp_b_valid", flit_valid_o2, 1'b1);
    check("bp_b", flit_o2, {2'b00, 32'hB});
    check("bp_b_credit", credit_cnt_o2, 2'd0);
    data_i2 = 32'hC;
    tick();
    check("bp_after_b", flit_valid_o2, 1'b0);
    data_valid2 = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
